// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
// Bundles the button-side signals of button_conditioner.
//   btn_raw      raw, asynchronous, bouncy button inputs (active-high)
//   btn_level    debounced level per button
//   btn_press    1-cycle pulse: debounced rising edge or auto-repeat tick
//   btn_release  1-cycle pulse on debounced falling edge
//   any_press    OR-reduce of btn_press, same cycle
// Modports:
//   master  the side that owns the buttons and consumes the conditioned view
//   slave   the conditioner itself
// N_BTN must match the N_BTN of the attached button_conditioner.
// ---------------------------------------------------------------------------
interface button_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             any_press;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  any_press
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output any_press
    );
endinterface

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Conditions the Basys push-buttons, bit order {C,L,U,R,D} = [4:0], for the
// game/cursor logic: per button a 2-flop synchroniser, a counter debounce,
// registered one-cycle press/release pulses and optional auto-repeat.
// Downstream logic steps exactly once per btn_press pulse.
//
// Parameters
//   N_BTN            number of buttons
//   DEBOUNCE_CYCLES  consecutive cycles the synced input must differ from
//                    btn_level before btn_level flips (>= 1)
//   REPEAT_DELAY     hold cycles after the press pulse before the first
//                    repeat pulse; 0 disables auto-repeat
//   REPEAT_PERIOD    cycles between repeat pulses once repeating (>= 1)
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (release synchronous to clk upstream)
//   bus    button_conditioner_if.slave: btn_raw in; btn_level, btn_press,
//          btn_release, any_press out (all outputs registered)
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_conditioner_if.slave  bus
);
    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HC_W   = $clog2(HC_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Only meaningful when REPEAT_DELAY > 0; the repeat logic is gated on that.
    localparam logic [HC_W-1:0]  DELAY_LAST  = HC_W'(REPEAT_DELAY - 1);
    localparam logic [HC_W-1:0]  PERIOD_LAST = HC_W'(REPEAT_PERIOD - 1);

    // Synchroniser; only s2 is used by the debounce logic.
    logic [N_BTN-1:0] s1, s2;

    // Registered state and its next-state values.
    logic [N_BTN-1:0] level_q,   level_d;
    logic [N_BTN-1:0] press_q,   press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic             any_q,     any_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    // Hold counter: cycles since the press pulse or since the last repeat.
    logic [HC_W-1:0]  hc_q  [N_BTN];
    logic [HC_W-1:0]  hc_d  [N_BTN];
    // Set once the first repeat has fired; selects DELAY vs PERIOD spacing.
    logic [N_BTN-1:0] rep_q,     rep_d;

    // NOTE: every next-state variable gets a default at the top of the block,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        rep_d     = rep_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            hc_d[i]  = hc_q[i];

            // Debounce: count consecutive mismatch cycles, flip on the last one.
            if (s2[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]     = '0;
                level_d[i]   = s2[i];
                press_d[i]   = s2[i];
                release_d[i] = ~s2[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            // Auto-repeat. The hold counter restarts on the press cycle and is
            // cleared while released, so a release edge can never coincide
            // with a repeat tick. It always returns to 0 on a tick, so it
            // never runs past HC_MAX.
            if (REPEAT_DELAY > 0) begin
                if (!level_q[i] || press_d[i] || release_d[i]) begin
                    hc_d[i]  = '0;
                    rep_d[i] = 1'b0;
                end else if (hc_q[i] == (rep_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
                    hc_d[i]    = '0;
                    rep_d[i]   = 1'b1;
                    press_d[i] = 1'b1;
                end else begin
                    hc_d[i] = hc_q[i] + HC_W'(1);
                end
            end
        end
        any_d = |press_d;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
            rep_q     <= '0;
            // NOTE: the per-button counter arrays are real state that must
            // restart from 0 after a mid-hold reset, so they are reset too.
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
                hc_q[i]  <= '0;
            end
        end else begin
            s1        <= bus.btn_raw;
            s2        <= s1;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= any_d;
            rep_q     <= rep_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
                hc_q[i]  <= hc_d[i];
            end
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.any_press   = any_q;

endmodule
